// File: rtl/seq_shift_pkg.sv
// Shared types and operation codes for the sequential multi-position shifter.
package seq_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] SEL_PASS = 2'b00;
  localparam logic [1:0] SEL_SHL  = 2'b01;
  localparam logic [1:0] SEL_SHR  = 2'b10;
  localparam logic [1:0] SEL_CLR  = 2'b11;

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shifter applied to the result register each SHIFT cycle.
// SEQ_SHIFT_ROTATE_EN turns the 11 code into rotate-left.
module shift_step
  import seq_shift_pkg::*;
#(
  parameter int unsigned n = 4
) (
  input  logic [n-1:0] value,
  input  logic [1:0]   sel,
  output logic [n-1:0] result
);

  always_comb begin
    result = value;
    case (sel)
      SEL_SHL: result = {value[n-2:0], 1'b0};
      SEL_SHR: result = {value[n-1], value[n-1:1]};
`ifdef SEQ_SHIFT_ROTATE_EN
      SEL_CLR: result = {value[n-2:0], value[n-1]};
`endif
      default: result = value;
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: one bit-step per clock under a start/busy/done handshake.
// Optional SEQ_SHIFT_ROTATE_EN makes H_sel=11 rotate-left instead of clear.
module seq_shift_unit
  import seq_shift_pkg::*;
#(
  parameter int unsigned n     = 4,
  parameter int unsigned CNT_W = $clog2(n) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [n-1:0]     Bus_B,
  input  logic [1:0]       H_sel,
  input  logic [CNT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [n-1:0]     Shif_out
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(n);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [n-1:0]     res_q, res_d;
  logic [n-1:0]     step_res;
  logic [CNT_W-1:0] amt_sat;
  logic             step_op;

  assign amt_sat = (amt > CntMax) ? CntMax : amt;

  // Operations that need the SHIFT state; everything else finishes in one cycle.
`ifdef SEQ_SHIFT_ROTATE_EN
  assign step_op = (H_sel != SEL_PASS);
`else
  assign step_op = (H_sel == SEL_SHL) || (H_sel == SEL_SHR);
`endif

  shift_step #(
    .n(n)
  ) u_shift_step (
    .value  (res_q),
    .sel    (sel_q),
    .result (step_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sel_q <= SEL_PASS;
      res_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      res_q <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (step_op && (amt_sat != '0)) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (cnt_q == CntOne) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    res_d = res_q;
    if ((state_q == IDLE) && start) begin
      cnt_d = amt_sat;
      sel_d = H_sel;
      res_d = Bus_B;
`ifndef SEQ_SHIFT_ROTATE_EN
      if (H_sel == SEL_CLR) begin
        res_d = '0;
      end
`endif
    end else if (state_q == SHIFT) begin
      cnt_d = cnt_q - CntOne;
      res_d = step_res;
    end
  end

  always_comb begin
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    Shif_out = res_q;
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit (n=4): stimulus pushes expected result and done cycle.
module tb_seq_shift_unit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] Bus_B;
  logic [1:0] H_sel;
  logic [2:0] amt;
  logic       busy;
  logic       done;
  logic [3:0] Shif_out;

  typedef struct {
    int         cyc;
    logic [3:0] res;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;

  seq_shift_unit #(
    .n    (4),
    .CNT_W(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .Bus_B    (Bus_B),
    .H_sel    (H_sel),
    .amt      (amt),
    .busy     (busy),
    .done     (done),
    .Shif_out (Shif_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the head of the scoreboard in value and cycle.
  always @(negedge clk) begin
    if (!rst && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: cycle %0d result %b, expected no done", cyc, Shif_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ((Shif_out !== e.res) || (cyc != e.cyc)) begin
          errors++;
          $display("FAIL done_result: got %b at cycle %0d, expected %b at cycle %0d",
                   Shif_out, cyc, e.res, e.cyc);
        end
      end
    end
  end

  // Called at a negedge: drives start for one cycle, returns at the next negedge.
  task automatic issue(input logic [3:0] b, input logic [1:0] s, input logic [2:0] a,
                       input logic [3:0] r, input int lat);
    exp_t e;
    Bus_B = b;
    H_sel = s;
    amt   = a;
    start = 1'b1;
    e.cyc = cyc + lat;
    e.res = r;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    Bus_B = ~b;
    H_sel = ~s;
    amt   = 3'd5;
  endtask

  task automatic wait_idle(input logic [3:0] hold);
    int n_wait;
    n_wait = 0;
    while ((sb.size() != 0) && (n_wait < 40)) begin
      @(negedge clk);
      n_wait++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", n_wait);
      sb.delete();
    end
    @(negedge clk);
    @(negedge clk);
    chk("result_hold", {28'd0, Shif_out}, {28'd0, hold});
  endtask

  initial begin
    cyc    = 0;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b1;
    Bus_B  = 4'b1111;
    H_sel  = 2'b00;
    amt    = 3'd0;
    repeat (3) @(negedge clk);
    chk("reset_out", {28'd0, Shif_out}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {31'd0, busy}, 32'd0);

    // SHL by 2: busy for three cycles, done on the third.
    issue(4'b0011, 2'b01, 3'd2, 4'b1100, 3);
    chk("busy_t1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("busy_t2", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("busy_t3", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("busy_t4", {31'd0, busy}, 32'd0);
    wait_idle(4'b1100);

    issue(4'b1000, 2'b10, 3'd3, 4'b1111, 4);
    wait_idle(4'b1111);
    issue(4'b0100, 2'b10, 3'd1, 4'b0010, 2);
    wait_idle(4'b0010);
    issue(4'b1011, 2'b01, 3'd7, 4'b0000, 5);
    wait_idle(4'b0000);
    issue(4'b1011, 2'b00, 3'd5, 4'b1011, 1);
    wait_idle(4'b1011);
    issue(4'b0110, 2'b01, 3'd0, 4'b0110, 1);
    wait_idle(4'b0110);
    issue(4'b1000, 2'b10, 3'd4, 4'b1111, 5);
    wait_idle(4'b1111);

    // Start while busy is ignored.
    issue(4'b0001, 2'b01, 3'd3, 4'b1000, 4);
    Bus_B = 4'b1111;
    H_sel = 2'b00;
    amt   = 3'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(4'b1000);

    // Reset mid-shift aborts without a done pulse.
    issue(4'b0110, 2'b10, 3'd4, 4'b0000, 5);
    rst   = 1'b1;
    start = 1'b1;
    sb.delete();
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("abort_out", {28'd0, Shif_out}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (6) @(negedge clk);
    issue(4'b0110, 2'b10, 3'd1, 4'b0011, 2);
    wait_idle(4'b0011);

`ifdef SEQ_SHIFT_ROTATE_EN
    issue(4'b1001, 2'b11, 3'd1, 4'b0011, 2);
    wait_idle(4'b0011);
    issue(4'b1001, 2'b11, 3'd7, 4'b1001, 5);
    wait_idle(4'b1001);
    issue(4'b1010, 2'b11, 3'd0, 4'b1010, 1);
    wait_idle(4'b1010);
`else
    issue(4'b1001, 2'b11, 3'd1, 4'b0000, 1);
    wait_idle(4'b0000);
    issue(4'b1010, 2'b11, 3'd7, 4'b0000, 1);
    wait_idle(4'b0000);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
